// File: rtl/vreg_sched.sv
// vreg_sched: per-line video register write scheduler ("copper").
// Replays a CPU-loaded list of (line, addr, data) writes every frame, one strobe per clock.
module vreg_sched #(
    parameter int DEPTH  = 8,
    parameter int LINE_W = 9,
    parameter int ADDR_W = 5
) (
    input  logic                      clk,
    input  logic                      res_n,
    input  logic [7:0]                d,
    input  logic                      ql_wr,
    input  logic                      qh_wr,
    input  logic                      qa_wr,
    input  logic                      qd_wr,
    input  logic                      qctl_wr,
    input  logic                      int_start,
    input  logic                      line_start_s,
    output logic                      reg_wr,
    output logic [ADDR_W-1:0]         reg_addr,
    output logic [7:0]                reg_data,
    output logic [$clog2(DEPTH):0]    q_count,
    output logic                      q_full,
    output logic                      q_ovf,
    output logic                      busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]     CNT_FULL = CW'(DEPTH);
    localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);
    localparam logic [LINE_W-1:0] LINE_MAX = {LINE_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [CW-1:0]       rd_ptr_r, rd_ptr_nxt_s;
    logic [CW-1:0]       count_r, count_nxt_s;
    logic                full_r, ovf_r, enable_r, ls_dly_r, busy_r;
    logic [LINE_W-1:0]   stage_line_r, line_cnt_r;
    logic [ADDR_W-1:0]   stage_addr_r, reg_addr_r;
    logic [7:0]          reg_data_r;
    logic                reg_wr_r, issue_s, flush_s, push_s, ovf_set_s;
    logic [PW-1:0]       rd_idx_s;

    logic [LINE_W-1:0]   line_mem_r [DEPTH];
    logic [ADDR_W-1:0]   addr_mem_r [DEPTH];
    logic [7:0]          data_mem_r [DEPTH];

    // Flush dominates a coincident push; a push into a full list only raises the sticky flag.
    assign flush_s   = qctl_wr & d[1];
    assign push_s    = qd_wr & ~flush_s & (count_r != CNT_FULL);
    assign ovf_set_s = qd_wr & ~flush_s & (count_r == CNT_FULL);
    assign rd_idx_s  = rd_ptr_r[PW-1:0];

    // Staging registers and enable bit
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            stage_line_r <= '0;
            stage_addr_r <= '0;
            enable_r     <= 1'b0;
        end else begin
            if (ql_wr)   stage_line_r[7:0]        <= d;
            if (qh_wr)   stage_line_r[LINE_W-1]   <= d[0];
            if (qa_wr)   stage_addr_r             <= d[ADDR_W-1:0];
            if (qctl_wr) enable_r                 <= d[0];
        end
    end

    // Entry storage; contents are meaningless beyond count_r so no reset is needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            line_mem_r[count_r[PW-1:0]] <= stage_line_r;
            addr_mem_r[count_r[PW-1:0]] <= stage_addr_r;
            data_mem_r[count_r[PW-1:0]] <= d;
        end
    end

    // Next list count
    always_comb begin
        count_nxt_s = count_r;
        if (flush_s) begin
            count_nxt_s = '0;
        end else if (push_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // List count, full and sticky overflow flags
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            count_r <= '0;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_FULL);
            if (flush_s)        ovf_r <= 1'b0;
            else if (ovf_set_s) ovf_r <= 1'b1;
        end
    end

    // Saturating line counter; the delayed line pulse lets ISSUE see the updated count
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            line_cnt_r <= '0;
            ls_dly_r   <= 1'b0;
        end else begin
            ls_dly_r <= line_start_s;
            if (int_start)
                line_cnt_r <= '0;
            else if (line_start_s && (line_cnt_r != LINE_MAX))
                line_cnt_r <= line_cnt_r + LINE_ONE;
        end
    end

    // Replay FSM next-state and issue decision
    always_comb begin
        state_nxt_s  = state_r;
        rd_ptr_nxt_s = rd_ptr_r;
        issue_s      = 1'b0;
        if (flush_s) begin
            state_nxt_s  = ST_IDLE;
            rd_ptr_nxt_s = '0;
        end else if (int_start) begin
            if (enable_r && (count_r != '0)) begin
                state_nxt_s  = ST_ISSUE;
                rd_ptr_nxt_s = '0;
            end else begin
                state_nxt_s  = ST_IDLE;
            end
        end else if (!enable_r) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_IDLE;
                ST_WAIT: begin
                    if (ls_dly_r) state_nxt_s = ST_ISSUE;
                    else          state_nxt_s = ST_WAIT;
                end
                ST_ISSUE: begin
                    if (rd_ptr_r == count_r) begin
                        state_nxt_s = ST_IDLE;
                    end else if (line_mem_r[rd_idx_s] <= line_cnt_r) begin
                        issue_s      = 1'b1;
                        rd_ptr_nxt_s = rd_ptr_r + CNT_ONE;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM state, read pointer and registered strobe outputs
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_r    <= ST_IDLE;
            rd_ptr_r   <= '0;
            reg_wr_r   <= 1'b0;
            reg_addr_r <= '0;
            reg_data_r <= '0;
            busy_r     <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            reg_wr_r <= issue_s;
            busy_r   <= (state_nxt_s == ST_ISSUE);
            if (issue_s) begin
                reg_addr_r <= addr_mem_r[rd_idx_s];
                reg_data_r <= data_mem_r[rd_idx_s];
            end
        end
    end

    assign reg_wr   = reg_wr_r;
    assign reg_addr = reg_addr_r;
    assign reg_data = reg_data_r;
    assign q_count  = count_r;
    assign q_full   = full_r;
    assign q_ovf    = ovf_r;
    assign busy     = busy_r;
endmodule

// File: doc/vreg_sched.md
Name: vreg_sched

Overview:
- Per-line video register write scheduler, a "copper" for the video port register file.
- The CPU loads a small list of (line, register index, data) entries through port writes.
- Each frame, the block replays the list in order. On reaching each entry's target line it issues a one-cycle register write strobe with address and data.
- Output feeds the video port register write mux, alongside the CPU strobes. Mid-frame changes (border, offsets, palsel, vpage) then happen without CPU interrupts.

Parameters:
- DEPTH, 8, list entries; power of two, 2..16.
- LINE_W, 9, line number width.
- ADDR_W, 5, target register index width (up to 32 video registers).

Ports:
- clk  in  1  system clock.
- res_n  in  1  asynchronous active-low reset.
- d  in  8  CPU port write data.
- ql_wr  in  1  stage line[7:0] <= d.
- qh_wr  in  1  stage line[8] <= d[0].
- qa_wr  in  1  stage addr <= d[ADDR_W-1:0].
- qd_wr  in  1  push entry {staged line, staged addr, d}.
- qctl_wr  in  1  control write: d[0]=enable; d[1]=flush (self-clearing).
- int_start  in  1  frame start pulse, 1 clk.
- line_start_s  in  1  line start pulse, 1 clk.
- reg_wr  out  1  register write strobe, 1 clk per entry.
- reg_addr  out  ADDR_W  target register index, valid with reg_wr.
- reg_data  out  8  write data, valid with reg_wr.
- q_count  out  $clog2(DEPTH)+1  entries loaded.
- q_full  out  1  q_count==DEPTH.
- q_ovf  out  1  sticky: push attempted while full.
- busy  out  1  FSM in ISSUE.

Behaviour:
- Reset (async, res_n=0):
  - Outputs: reg_wr=0, reg_addr=0, reg_data=0, q_count=0, q_ovf=0.
  - Internal: enable=0, staged line/addr=0, rd_ptr=0, line_cnt=0, state=IDLE.
  - Entry RAM contents are don't-care.
- List load:
  - qd_wr with q_count<DEPTH writes entry[q_count] and increments q_count.
  - qd_wr while full: entry ignored, q_ovf<=1.
  - Staged line/addr keep their values after a push, so consecutive pushes may reuse them.
  - Entries are not consumed by replay. The list persists across frames until flush.
- Control:
  - Flush: q_count<=0, q_ovf<=0, rd_ptr<=0, state<=IDLE, and the reg_wr register is forced 0 in the same cycle.
  - If qctl_wr and qd_wr coincide, flush wins and the push is dropped.
  - Clearing enable: state<=IDLE at the next edge; a strobe already registered still completes.
- Line counter:
  - int_start sets line_cnt<=0.
  - line_start_s increments line_cnt, saturating at 2^LINE_W-1.
  - If both pulse together, int_start wins.
- FSM states: IDLE, WAIT, ISSUE.
  - Any state, on int_start with enable=1 and q_count>0: rd_ptr<=0, state<=ISSUE.
  - int_start aborts an in-progress burst. Lines 0 entries are issued without waiting for a line_start_s.
  - int_start with enable=0 or an empty list: state<=IDLE.
  - WAIT, on line_start_s: state<=ISSUE.
  - ISSUE, per clock, comparing against the current (already updated) line_cnt:
    - rd_ptr==q_count: state<=IDLE (list exhausted for this frame).
    - entry[rd_ptr].line <= line_cnt: register reg_wr=1 with the entry's addr and data, rd_ptr++, stay in ISSUE.
    - otherwise: state<=WAIT.
  - One entry per clock, so a burst of N same-line entries gives N back-to-back strobes.
  - Entries whose line is already past are issued late, never skipped.
  - The list must be sorted ascending by line. Out-of-order entries block later ones until line_cnt reaches them.
  - IDLE exits only on int_start.
- Latency: a line_start_s sampled at edge E0 gives the first reg_wr high in the cycle after edge E2.
- Output registers:
  - reg_wr is 0 whenever no entry is issued in the previous ISSUE cycle.
  - reg_addr and reg_data hold their last values while reg_wr=0.
- Push during replay is allowed:
  - The new entry is visible to ISSUE from the next clock if rd_ptr has not yet passed it.
  - If the FSM is already IDLE (list exhausted), the entry is issued next frame.
- busy=1 iff state==ISSUE.

Test Plan:
- Load 3 entries (line 0 addr 2 data 0x11; line 5 addr 0 data 0x22; line 5 addr 1 data 0x33), enable, int_start -> reg_wr with (2,0x11) 2 clocks after int_start. After the 5th line_start_s, back-to-back strobes (0,0x22) then (1,0x33). No other strobes that frame. Same sequence repeats after the next int_start.
- Push 9 entries with DEPTH=8 -> q_count=8, q_full=1, q_ovf=1, entry 9 is never issued. Flush -> q_count=0, q_ovf=0, no strobes at the next int_start.
- Entry at line 3 pushed while line_cnt=7 and the FSM is in WAIT -> issued at the next line_start_s (line 8), late but not skipped.
- int_start coincident with line_start_s while line_cnt=100 -> line_cnt=0. Line-0 entries issue; no line-101 entries issue.
- Assert res_n low mid-burst of 4 same-line entries -> reg_wr=0 and q_count=0 immediately. After release, no strobe until a reload, enable and int_start.
- Flush in the cycle after a strobe is registered for a 2-entry burst -> at most the first strobe is seen, and the second never appears.
